// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch per cycle, reads the instruction storage at
// the accept edge, carries the result through a fixed-latency pipeline and returns it through
// an in-order response queue with valid/ready backpressure. Flush drops everything in flight.
module imem_responder #(
  parameter int unsigned      WIDTH   = 64,
  parameter logic [WIDTH-1:0] BASE    = 64'h8000_0000,
  parameter int unsigned      AW      = 10,
  parameter int unsigned      LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_inst,
  output logic [WIDTH-1:0] rsp_addr,
  output logic             rsp_fault,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [31:0]      prog_data
);

  localparam int unsigned      Depth = LATENCY + 1;
  localparam int unsigned      CntW  = $clog2(Depth + 1);
  localparam int unsigned      IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [WIDTH-1:0] Limit = BASE + (WIDTH'(4) << AW);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] addr;
    logic [31:0]      inst;
    logic             fault;
  } entry_t;

  logic [31:0]      mem_q [2**AW];
  logic             accept;
  logic             pop;
  logic             fetch_fault;
  logic [WIDTH-1:0] offset;
  logic [AW-1:0]    word_idx;
  entry_t           in_item;
  entry_t           push_item;
  entry_t           q_q [Depth];
  entry_t           q_d [Depth];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  out_q, out_d;

  // Outstanding counts pipeline and queue together, so the queue can never overflow.
  assign req_ready = rst & (out_q < CntW'(Depth));
  assign accept    = req_valid & req_ready;

  assign offset      = req_addr - BASE;
  assign word_idx    = AW'(offset >> 2);
  assign fetch_fault = (req_addr[1:0] != 2'b00) | (req_addr < BASE) | (req_addr >= Limit);

  // Entry formed at the accept edge; faulting fetches skip the storage read.
  always_comb begin
    in_item = '0;
    if (accept) begin
      in_item.valid = 1'b1;
      in_item.addr  = req_addr;
      in_item.fault = fetch_fault;
      if (!fetch_fault) in_item.inst = mem_q[word_idx];
    end
  end

  // Storage write port; never reset, usable during reset. Same-edge fetch sees old data.
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  // The final pipeline stage is the queue slot itself, so only LATENCY-1 stages are registered.
  if (LATENCY == 1) begin : g_nopipe
    assign push_item = in_item;
  end else begin : g_pipe
    entry_t pipe_q [LATENCY-1];

    // Shift accepted entries down the pipe; flush kills older stages but keeps the new fetch.
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= in_item;
        for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= flush ? '0 : pipe_q[i-1];
      end
    end

    // Entry leaving the pipe this edge, dropped if a flush is in progress.
    always_comb begin
      push_item = pipe_q[LATENCY-2];
      if (flush) push_item = '0;
    end
  end

  // Flush hides the head so that no pop can happen in the redirect cycle.
  assign rsp_valid = q_q[0].valid & ~flush;
  assign rsp_inst  = q_q[0].inst;
  assign rsp_addr  = q_q[0].addr;
  assign rsp_fault = q_q[0].fault;
  assign pop       = rsp_valid & rsp_ready;

  // Shift-register queue: pop shifts toward the head, push fills the first free slot.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (flush) begin
      for (int i = 0; i < Depth; i++) q_d[i] = '0;
      cnt_d = '0;
    end else if (pop) begin
      for (int i = 0; i < Depth - 1; i++) q_d[i] = q_q[i+1];
      q_d[Depth-1] = '0;
      cnt_d        = cnt_q - CntW'(1);
    end
    if (push_item.valid) begin
      q_d[IdxW'(cnt_d)] = push_item;
      cnt_d             = cnt_d + CntW'(1);
    end
  end

  // Queue state; vacant slots are held at zero so idle outputs read as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) q_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  // Next outstanding count; a flush leaves only the redirected fetch, if one was accepted.
  always_comb begin
    if (flush) out_d = CntW'(accept);
    else       out_d = out_q + CntW'(accept) - CntW'(pop);
  end

  // Outstanding-request counter.
  always_ff @(posedge clk) begin
    if (!rst) out_q <= '0;
    else      out_q <= out_d;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based reference model.
module tb_imem_responder;

  localparam int unsigned LAT  = 2;
  localparam int unsigned AW   = 10;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr  = '0;
  logic        flush     = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic [63:0] rsp_addr;
  logic        rsp_fault;
  logic        prog_we   = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;

  imem_responder #(
    .WIDTH  (64),
    .BASE   (BASE),
    .AW     (AW),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .flush    (flush),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_inst (rsp_inst),
    .rsp_addr (rsp_addr),
    .rsp_fault(rsp_fault),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] inst;
    logic        fault;
    int unsigned acc;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mem_m [1024];
  int unsigned ecnt     = 0;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Head is visible LAT-1 edges after its accept edge, unless a flush hides it.
  function automatic bit m_valid();
    return !flush && mq.size() > 0 && (mq[0].acc + LAT - 1 <= ecnt);
  endfunction

  function automatic bit m_ready();
    return rst && mq.size() < LAT + 1;
  endfunction

  function automatic logic [31:0] word_init(input int i);
    case (i)
      0:       return 32'h0000_0297;
      1:       return 32'h0202_8593;
      5:       return 32'h0050_0513;
      16:      return 32'h0100_0613;
      1023:    return 32'hCAFE_F00D;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] rand_addr();
    int unsigned s = $urandom_range(0, 15);
    logic [63:0] a = BASE + 64'(4 * $urandom_range(0, 1023));
    if (s == 0)      a = a + 64'($urandom_range(1, 3));
    else if (s == 1) a = BASE - 64'(4 * $urandom_range(1, 8));
    else if (s == 2) a = BASE + 64'd4096 + 64'(4 * $urandom_range(0, 8));
    else if (s == 3) a = {$urandom, $urandom};
    return a;
  endfunction

  // Reference model update at each rising edge.
  always @(posedge clk) begin
    bit          v, rdy, acc;
    ment_t       it;
    logic [63:0] off;
    v   = m_valid();
    rdy = m_ready();
    acc = req_valid && rdy;
    if (acc) begin
      off      = req_addr - BASE;
      it.addr  = req_addr;
      it.fault = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (req_addr >= BASE + 64'd4096);
      it.inst  = it.fault ? 32'h0 : mem_m[off[11:2]];
      it.acc   = ecnt + 1;
    end
    if (!rst)                  mq.delete();
    else if (flush)            mq.delete();
    else if (v && rsp_ready)   void'(mq.pop_front());
    if (acc) mq.push_back(it);
    if (prog_we) mem_m[prog_addr] = prog_data;
    ecnt = ecnt + 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit v;
    if (ecnt >= 1) begin
      v = m_valid();
      check("req_ready", req_ready, m_ready());
      check("rsp_valid", rsp_valid, v);
      if (v) begin
        check("rsp_inst", rsp_inst, mq[0].inst);
        check("rsp_addr", rsp_addr, mq[0].addr);
        check("rsp_fault", rsp_fault, mq[0].fault);
      end
    end
  end

  task automatic cyc(input bit rv, input logic [63:0] a, input bit rr, input bit fl, input bit rs);
    @(posedge clk);
    #1;
    req_valid = rv;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    rst       = rs;
    prog_we   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          acc_n;
    logic [63:0] pc;

    // Preload storage while held in reset.
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk);
      #1;
      prog_we   = 1'b1;
      prog_addr = 10'(i);
      prog_data = word_init(i);
    end
    cyc(0, '0, 0, 0, 0);
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_inst", rsp_inst, 0);
    check("reset rsp_addr", rsp_addr, 0);
    check("reset rsp_fault", rsp_fault, 0);
    cyc(0, '0, 1, 0, 1);
    check("release req_ready", req_ready, 1);

    // Basic read, back to back.
    cyc(1, 64'h8000_0000, 1, 0, 1);
    cyc(1, 64'h8000_0004, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);
    check("basic w0 valid", rsp_valid, 1);
    check("basic w0 inst", rsp_inst, 32'h0000_0297);
    check("basic w0 addr", rsp_addr, 64'h8000_0000);
    check("basic w0 fault", rsp_fault, 0);
    cyc(0, '0, 1, 0, 1);
    check("basic w1 inst", rsp_inst, 32'h0202_8593);
    check("basic w1 addr", rsp_addr, 64'h8000_0004);
    cyc(0, '0, 1, 0, 1);

    // Full backpressure.
    acc_n = 0;
    pc    = 64'h8000_0020;
    for (int i = 0; i < 8; i++) begin
      cyc(1, pc, 0, 0, 1);
      if (req_ready) begin
        acc_n++;
        pc = pc + 64'd4;
      end
    end
    check("bp accept count", 64'(acc_n), 64'd3);
    check("bp head addr", rsp_addr, 64'h8000_0020);
    cyc(0, '0, 1, 0, 1);
    check("bp ready before pop", req_ready, 0);
    cyc(0, '0, 1, 0, 1);
    check("bp ready after pop", req_ready, 1);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 1);

    // Fault cases.
    cyc(1, 64'h8000_0002, 1, 0, 1);
    cyc(1, 64'h7FFF_FFFC, 1, 0, 1);
    cyc(1, 64'h8000_1000, 1, 0, 1);
    check("misaligned fault", rsp_fault, 1);
    check("misaligned inst", rsp_inst, 0);
    cyc(1, 64'h8000_0FFC, 1, 0, 1);
    check("below base fault", rsp_fault, 1);
    cyc(0, '0, 1, 0, 1);
    check("above limit fault", rsp_fault, 1);
    cyc(0, '0, 1, 0, 1);
    check("last word fault", rsp_fault, 0);
    check("last word inst", rsp_inst, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 1);

    // Flush with redirect.
    cyc(1, 64'h8000_0008, 1, 0, 1);
    cyc(1, 64'h8000_000C, 1, 0, 1);
    cyc(1, 64'h8000_0010, 1, 0, 1);
    cyc(1, 64'h8000_0040, 1, 1, 1);
    check("flush rsp_valid", rsp_valid, 0);
    cyc(0, '0, 1, 0, 1);
    check("post flush idle", rsp_valid, 0);
    cyc(0, '0, 1, 0, 1);
    check("redirect valid", rsp_valid, 1);
    check("redirect inst", rsp_inst, 32'h0100_0613);
    check("redirect addr", rsp_addr, 64'h8000_0040);
    cyc(0, '0, 1, 0, 1);
    check("redirect only", rsp_valid, 0);

    // Reset in mid-operation.
    for (int i = 0; i < 3; i++) cyc(1, 64'h8000_0000, 0, 0, 1);
    cyc(0, '0, 0, 0, 0);
    check("mid reset ready", req_ready, 0);
    cyc(0, '0, 0, 0, 0);
    check("mid reset rsp_valid", rsp_valid, 0);
    cyc(0, '0, 1, 0, 1);
    check("mid reset release", req_ready, 1);
    check("no stale rsp", rsp_valid, 0);
    cyc(1, 64'h8000_0004, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);
    check("post reset inst", rsp_inst, 32'h0202_8593);
    cyc(0, '0, 1, 0, 1);

    // Write/read collision on word 5.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 64'h8000_0014;
    rsp_ready = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 10'd5;
    prog_data = 32'hDEAD_BEEF;
    @(negedge clk);
    cyc(1, 64'h8000_0014, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);
    check("collision old", rsp_inst, 32'h0050_0513);
    cyc(0, '0, 1, 0, 1);
    check("collision new", rsp_inst, 32'hDEAD_BEEF);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_addr  = rand_addr();
      prog_we   = ($urandom_range(0, 9) == 0);
      prog_addr = 10'($urandom_range(0, 1023));
      prog_data = $urandom;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) cyc(0, '0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves fetch addresses issued by the fetch unit's PC register. It accepts one fetch request per cycle over a valid/ready handshake and returns the 32-bit instruction word after a fixed pipeline latency. Responses are returned in order through a response queue with valid/ready backpressure. A flush input discards all in-flight fetches on a branch redirect. It sits between the PC-generation stage and decode, and owns the instruction storage, which the bench preloads through a write port.

## Interface
- WIDTH, 64, address width (matches PC width)
- BASE, 64'h80000000, address of instruction word 0 (PC entry point)
- AW, 10, word-index width; storage depth = 2**AW words of 32 bits
- LATENCY, 2, request-to-response latency in cycles, legal range 1..4
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low; 0 = reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  WIDTH  fetch address (PC)
- flush  in  1  discard all in-flight and queued responses
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_inst  out  32  instruction word
- rsp_addr  out  WIDTH  address that produced this response
- rsp_fault  out  1  fetch fault: misaligned or out of range
- prog_we  in  1  storage write enable
- prog_addr  in  AW  storage word index
- prog_data  in  32  storage write data

## Operation
- **Accept.** A request is accepted on an edge where req_valid & req_ready = 1. Storage is read synchronously at the accept edge.
- **Fault detection.** Fault when req_addr[1:0] != 0, when req_addr < BASE, or when req_addr >= BASE + 4·2**AW.
  - On a fault: no storage read, rsp_inst = 0, rsp_fault = 1.
- **Indexing.** Word index = (req_addr − BASE) >> 2, truncated to AW bits. Compute in WIDTH bits with no sign extension.
- **Pipeline and queue.** An accepted request travels through a LATENCY-stage pipeline carrying {valid, addr, inst, fault}, then enters an in-order queue of LATENCY+1 entries.
- **Occupancy.**
  - outstanding = requests accepted and not yet popped, including both pipeline stages and queue entries.
  - +1 on accept, −1 on pop; both in the same edge leave it unchanged.
  - req_ready = rst & (outstanding < LATENCY+1).
  - req_ready never depends combinationally on rsp_ready (no same-cycle bypass).
- **Pop.** The queue head is presented on rsp_*. It is popped on an edge where rsp_valid & rsp_ready = 1.
  - While rsp_valid = 1 and rsp_ready = 0, all rsp_* outputs hold stable.
- **Flush.**
  - Edge with flush = 1: every pipeline stage and queue entry is invalidated and outstanding is cleared.
  - A request accepted in the same cycle (the redirected PC) is kept: it enters stage 1 and outstanding becomes 1.
  - During a flush cycle rsp_valid is forced to 0 combinationally, so no pop occurs.
- **Program writes.**
  - prog_we = 1 writes prog_data to word prog_addr at the edge.
  - A fetch accepted at the same edge, to the same word, returns the old data.
  - Writes are legal at any time, including during reset.
- **Reset** (rst = 0 at an edge):
  - Pipeline and queue are emptied and outstanding = 0.
  - rsp_valid = 0, rsp_inst = 0, rsp_addr = 0, rsp_fault = 0; req_ready = 0 while rst = 0.
  - Storage contents are not reset.
  - A reset in the middle of operation drops all outstanding responses.

## Timing
- **Latency.** A request accepted at edge k has rsp_valid = 1 from the cycle after edge k+LATENCY−1, provided the queue ahead of it is empty. For LATENCY = 1 this is the cycle immediately after acceptance.
- **Throughput.** One request per cycle is sustained indefinitely while rsp_ready = 1; steady-state outstanding = LATENCY.
- **Full backpressure.** With rsp_ready held at 0, exactly LATENCY+1 requests are accepted, then req_ready = 0 until the next pop.
  - req_ready returns to 1 in the cycle after the pop edge.
- **Order.** Responses leave in acceptance order. Faulting responses occupy their slot like any other.
- **Reset release.** req_ready = 1 in the first cycle with rst = 1.

## Test plan
- **Basic read.** Preload word 0 = 32'h00000297 and word 1 = 32'h02028593. Reset, then fetch 0x80000000 and 0x80000004 back-to-back with rsp_ready = 1. Required: responses at cycles +2 and +3 with those words, fault = 0, rsp_addr echoed.
- **Backpressure.** Hold rsp_ready = 0 and drive req_valid = 1 with consecutive PCs. Required: exactly 3 accepts (LATENCY = 2), then req_ready = 0 and rsp_* stable. Then release rsp_ready: responses arrive in order and req_ready rises one cycle after the first pop.
- **Faults.**
  - 0x80000002 → fault = 1, inst = 0.
  - 0x7FFFFFFC → fault = 1.
  - 0x80001000 (AW = 10) → fault = 1.
  - 0x80000FFC → fault = 0, returns word 1023.
- **Flush with redirect.** Issue 3 fetches, then assert flush in the same cycle as an accepted fetch of 0x80000040. Required: rsp_valid = 0 during the flush cycle; the only response afterwards is word 16, 2 cycles later.
- **Reset mid-operation.** Drop rst to 0 with 3 outstanding requests. Required: the next edge gives rsp_valid = 0 and req_ready = 0. After release, no stale responses appear and the first new fetch returns after 2 cycles.
- **Write/read collision.** Issue prog_we to word 5 = 32'hDEADBEEF at the same edge a fetch of 0x80000014 is accepted. Required: the response carries the old word; a second fetch returns 32'hDEADBEEF.
